// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game state codes and BCD score constants
package game_pkg;

    // Ball modules run only while the state code is zero, so PLAY must stay 0
    typedef enum logic [3:0] {
        ST_PLAY = 4'd0,
        ST_IDLE = 4'd1,
        ST_OVER = 4'd2
    } state_t;

    localparam int          BCD_DIGITS = 4;
    localparam logic [15:0] BCD_MAX    = 16'h9999;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - start key synchroniser, debouncer and press pulse
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_n,
    output logic pressed_level,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] stable_cnt;
    logic             sample_pressed;

    // The raw key is active-low; the filter works on the pressed sense
    assign sample_pressed = ~sync2;

    // Two-flop synchroniser; resets to the released (high) level
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            stable_cnt    <= '0;
            pressed_level <= 1'b0;
            press_pulse   <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            if (sample_pressed == pressed_level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                stable_cnt    <= '0;
                pressed_level <= sample_pressed;
                press_pulse   <= sample_pressed;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_fsm.sv
// rtl/game_fsm.sv - game flow controller: start key, play/over sequencing, BCD scores
module game_fsm
    import game_pkg::*;
#(
    parameter int NUM_BALLS       = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICKS_PER_SEC   = 50000000,
    parameter int LOCKOUT_CYCLES  = 25000000
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 start_key_n,
    input  logic [NUM_BALLS-1:0] ball_hit,
    output logic [3:0]           game_state,
    output logic [15:0]          score_bcd,
    output logic [15:0]          best_bcd,
    output logic                 new_record
);

    localparam int SEC_W  = $clog2(TICKS_PER_SEC + 1);
    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [SEC_W-1:0]  SEC_LAST = SEC_W'(TICKS_PER_SEC - 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCKOUT_CYCLES);

    state_t            state;
    logic [SEC_W-1:0]  sec_cnt;
    logic [LOCK_W-1:0] lock_cnt;
    logic              key_level;
    logic              key_pulse;
    logic              start_accept;
    logic              hit_any;

    // Saturating 4-digit BCD increment; a 9 digit rolls to 0 and carries up
    function automatic logic [15:0] bcd_inc(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        if (value != BCD_MAX) begin
            for (int d = 0; d < BCD_DIGITS; d++) begin
                if (carry) begin
                    if (result[4*d +: 4] == 4'd9) begin
                        result[4*d +: 4] = 4'd0;
                    end else begin
                        result[4*d +: 4] = result[4*d +: 4] + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
        return result;
    endfunction

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .key_n         (start_key_n),
        .pressed_level (key_level),
        .press_pulse   (key_pulse)
    );

    // The pulse only ever fires together with the accepted pressed level
    assign start_accept = key_pulse & key_level;
    assign hit_any      = |ball_hit;
    assign game_state   = state;

    // Game sequencing with registered score, best score and record flag
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            sec_cnt    <= '0;
            lock_cnt   <= '0;
            score_bcd  <= '0;
            best_bcd   <= '0;
            new_record <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_accept) begin
                        state      <= ST_PLAY;
                        score_bcd  <= '0;
                        sec_cnt    <= '0;
                        new_record <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    // A hit wins over a same-cycle score tick
                    if (hit_any) begin
                        state    <= ST_OVER;
                        lock_cnt <= '0;
                        if (score_bcd > best_bcd) begin
                            best_bcd   <= score_bcd;
                            new_record <= 1'b1;
                        end
                    end else if (sec_cnt == SEC_LAST) begin
                        sec_cnt   <= '0;
                        score_bcd <= bcd_inc(score_bcd);
                    end else begin
                        sec_cnt <= sec_cnt + 1'b1;
                    end
                end
                ST_OVER: begin
                    // Ball flags are stale here; only the lockout and key matter
                    if (start_accept && lock_cnt == LOCK_MAX) begin
                        state      <= ST_PLAY;
                        score_bcd  <= '0;
                        sec_cnt    <= '0;
                        new_record <= 1'b0;
                    end else if (lock_cnt != LOCK_MAX) begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_fsm.sv
// tb/tb_game_fsm.sv - randomized self-checking bench for game_fsm against a behavioural model
module tb_game_fsm;

    localparam int D = 4;
    localparam int T = 10;
    localparam int L = 20;

    logic        CLOCK_50;
    logic        reset;
    logic        start_key_n;
    logic [3:0]  ball_hit;
    logic [3:0]  game_state;
    logic [15:0] score_bcd;
    logic [15:0] best_bcd;
    logic        new_record;

    logic        key2;
    logic [3:0]  hit2;
    logic [3:0]  gs2;
    logic [15:0] score2;
    logic [15:0] best2;
    logic        rec2;

    int checks;
    int failures;

    game_fsm #(
        .NUM_BALLS(4), .DEBOUNCE_CYCLES(D), .TICKS_PER_SEC(T), .LOCKOUT_CYCLES(L)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start_key_n(start_key_n), .ball_hit(ball_hit),
        .game_state(game_state), .score_bcd(score_bcd), .best_bcd(best_bcd), .new_record(new_record)
    );

    game_fsm #(
        .NUM_BALLS(4), .DEBOUNCE_CYCLES(D), .TICKS_PER_SEC(1), .LOCKOUT_CYCLES(L)
    ) dut_fast (
        .CLOCK_50(CLOCK_50), .reset(reset), .start_key_n(key2), .ball_hit(hit2),
        .game_state(gs2), .score_bcd(score2), .best_bcd(best2), .new_record(rec2)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Behavioural model: mode 0 play, 1 idle, 2 over; scores as plain integers
    int m_mode;
    int m_score;
    int m_best;
    int m_sec;
    int m_lock;
    bit m_nr;
    bit m_pulse;
    bit m_acc;
    bit raw_q[$];
    bit filt_q[$];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        int x;
        x = v;
        to_bcd = '0;
        for (int i = 0; i < 4; i++) begin
            to_bcd[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
    endfunction

    task automatic model_reset();
        m_mode = 1; m_score = 0; m_best = 0; m_sec = 0; m_lock = 0;
        m_nr = 0; m_pulse = 0; m_acc = 0;
        raw_q = {1'b0, 1'b0};
        filt_q = {};
    endtask

    task automatic model_step();
        bit hit;
        bit p;
        bit filt;
        bit flip;
        hit = |ball_hit;
        p = m_pulse;
        if (m_mode == 1) begin
            if (p) begin m_mode = 0; m_score = 0; m_sec = 0; m_nr = 0; end
        end else if (m_mode == 0) begin
            if (hit) begin
                m_mode = 2;
                m_lock = 0;
                if (m_score > m_best) begin m_best = m_score; m_nr = 1; end
            end else begin
                m_sec++;
                if (m_sec == T) begin
                    m_sec = 0;
                    if (m_score < 9999) m_score++;
                end
            end
        end else begin
            if (p && m_lock == L) begin
                m_mode = 0; m_score = 0; m_sec = 0; m_nr = 0;
            end else if (m_lock < L) begin
                m_lock++;
            end
        end
        // Debounced key: filter sees the key two edges late, flips after D differing samples
        raw_q.push_back(~start_key_n);
        filt = raw_q[raw_q.size() - 3];
        filt_q.push_back(filt);
        m_pulse = 0;
        if (filt_q.size() >= D) begin
            flip = 1;
            for (int k = 0; k < D; k++)
                if (filt_q[filt_q.size() - 1 - k] == m_acc) flip = 0;
            if (flip) begin
                m_acc = ~m_acc;
                m_pulse = m_acc;
            end
        end
        while (raw_q.size() > 8) void'(raw_q.pop_front());
        while (filt_q.size() > 8) void'(filt_q.pop_front());
    endtask

    task automatic compare_all();
        check("state", {12'd0, game_state}, 16'(m_mode));
        check("score", score_bcd, to_bcd(m_score));
        check("best", best_bcd, to_bcd(m_best));
        check("record", {15'd0, new_record}, {15'd0, m_nr});
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        if (!reset) model_reset();
        else model_step();
        @(negedge CLOCK_50);
        compare_all();
    endtask

    task automatic wait_play(input string tag);
        int n;
        n = 0;
        while (game_state != 4'd0 && n < 30) begin
            tick();
            n++;
        end
        check(tag, {12'd0, game_state}, 16'd0);
    endtask

    initial begin
        int lat;
        int hold;
        checks = 0;
        failures = 0;
        reset = 1'b0;
        start_key_n = 1'b1;
        ball_hit = 4'd0;
        key2 = 1'b1;
        hit2 = 4'd0;
        model_reset();
        repeat (3) tick();
        check("rst_state", {12'd0, game_state}, 16'd1);
        check("rst_best", best_bcd, 16'h0000);
        reset = 1'b1;

        // Bouncing key never settles long enough
        for (int i = 0; i < 15; i++) begin
            start_key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) tick();
        end
        check("bounce_idle", {12'd0, game_state}, 16'd1);
        start_key_n = 1'b1;
        repeat (8) tick();

        // Clean press: 2 sync + 4 stable edges, then one more edge to PLAY
        start_key_n = 1'b0;
        lat = 0;
        while (game_state != 4'd0 && lat < 20) begin
            tick();
            lat++;
        end
        check("start_latency", 16'(lat), 16'd7);
        check("play_score0", score_bcd, 16'h0000);
        repeat (10) tick();
        start_key_n = 1'b1;
        repeat (69) tick();
        check("score_7", score_bcd, 16'h0007);

        // Hit on the tick cycle: score frozen, new best
        ball_hit = 4'b0100;
        tick();
        check("over_state", {12'd0, game_state}, 16'd2);
        check("over_score", score_bcd, 16'h0007);
        check("over_best", best_bcd, 16'h0007);
        check("over_record", {15'd0, new_record}, 16'd1);

        // Early press during lockout is discarded; stale hit held throughout
        repeat (3) tick();
        start_key_n = 1'b0;
        repeat (10) tick();
        check("lockout_hold", {12'd0, game_state}, 16'd2);
        start_key_n = 1'b1;
        repeat (20) tick();
        ball_hit = 4'd0;
        start_key_n = 1'b0;
        wait_play("relaunch");
        check("relaunch_score", score_bcd, 16'h0000);
        check("relaunch_record", {15'd0, new_record}, 16'd0);
        start_key_n = 1'b1;

        // Shorter run leaves best untouched
        repeat (59) tick();
        ball_hit = 4'b0001;
        tick();
        check("run2_score", score_bcd, 16'h0005);
        check("run2_best", best_bcd, 16'h0007);
        check("run2_record", {15'd0, new_record}, 16'd0);

        // Long run with carries
        ball_hit = 4'd0;
        repeat (25) tick();
        start_key_n = 1'b0;
        wait_play("run3_start");
        start_key_n = 1'b1;
        repeat (125) tick();
        check("score_125", score_bcd, 16'h0012);
        ball_hit = 4'b1000;
        tick();
        check("run3_best", best_bcd, 16'h0012);
        check("run3_record", {15'd0, new_record}, 16'd1);
        ball_hit = 4'd0;

        // Random key and hit activity checked cycle by cycle against the model
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                start_key_n = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 14);
            end
            hold--;
            ball_hit = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            tick();
        end
        ball_hit = 4'd0;
        start_key_n = 1'b1;

        // Fast-tick instance: every BCD carry and saturation at 9999
        key2 = 1'b0;
        lat = 0;
        while (gs2 != 4'd0 && lat < 20) begin
            tick();
            lat++;
        end
        check("fast_play", {12'd0, gs2}, 16'd0);
        key2 = 1'b1;
        for (int n = 1; n <= 10010; n++) begin
            tick();
            if (n == 100) check("carry_0100", score2, 16'h0100);
            else if (n >= 9999) check("saturate", score2, 16'h9999);
            else check("fast_score", score2, to_bcd(n));
        end

        // Asynchronous reset mid-run
        repeat (8) tick();
        start_key_n = 1'b0;
        wait_play("final_play");
        start_key_n = 1'b1;
        repeat (15) tick();
        check("prereset_state", {12'd0, game_state}, 16'd0);
        reset = 1'b0;
        #1;
        check("async_state", {12'd0, game_state}, 16'd1);
        check("async_best", best_bcd, 16'h0000);
        check("async_score", score_bcd, 16'h0000);
        check("async_record", {15'd0, new_record}, 16'd0);
        model_reset();
        repeat (2) tick();
        reset = 1'b1;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_fsm.md
Name: game_fsm

Overview:
Top-level game-flow controller that sits directly downstream of the ball instances and upstream of their game_state input.
- Debounces the start key.
- Sequences idle, play and game-over.
- Merges the per-ball collision flags.
- Keeps a BCD survival score and a best score for the VGA/HEX display stage.
- Encodes game_state so the ball modules run only while game_state == 0; any nonzero value holds every ball at its spawn point.

Parameters:
NUM_BALLS, 4, number of ball collision flags merged
DEBOUNCE_CYCLES, 1000000, stable-level cycles required before a key change is accepted (20 ms at 50 MHz)
TICKS_PER_SEC, 50000000, CLOCK_50 cycles per score increment
LOCKOUT_CYCLES, 25000000, minimum cycles in OVER before start is honoured

Ports:
CLOCK_50  in  1  system clock, 50 MHz, sole clock
reset  in  1  asynchronous, active-low reset
start_key_n  in  1  raw board KEY, active-low, asynchronous to CLOCK_50
ball_hit  in  NUM_BALLS  bit i = bit 0 of game_over_flag from ball i; sticky until the ball is held
game_state  out  4  current state code, registered
score_bcd  out  16  current survival seconds, 4 BCD digits
best_bcd  out  16  best score since reset, 4 BCD digits
new_record  out  1  high in OVER when the last run set a new best

Behaviour:
- Reset is asynchronous and active-low. Reset values:
  - game_state = ST_IDLE
  - score_bcd = 0
  - best_bcd = 0
  - new_record = 0
  - all counters = 0
  - debouncer output = released
- Reset asserted mid-game aborts immediately with no partial update of best_bcd.
- State codes:
  - ST_PLAY = 4'd0 (must be zero; balls run only here)
  - ST_IDLE = 4'd1
  - ST_OVER = 4'd2
  - 4'd3..15 are illegal and recover to ST_IDLE on the next edge.
- Start key path:
  - 2-FF synchroniser, then stability counter; the accepted level changes after DEBOUNCE_CYCLES consecutive equal samples.
  - start_pulse is a one-cycle pulse on the accepted released-to-pressed transition.
  - A held key produces exactly one pulse.
- hit_any = OR of ball_hit. It is sampled only in ST_PLAY and ignored elsewhere, because flags are stale until the balls re-spawn.
- ST_IDLE:
  - start_pulse -> ST_PLAY on the next edge.
  - On that edge score_bcd = 0, sec counter = 0, new_record = 0.
- ST_PLAY:
  - hit_any -> ST_OVER.
  - Otherwise the sec counter increments; at TICKS_PER_SEC-1 it wraps to 0 and score_bcd increments by 1 in BCD.
  - BCD carry: a 9 digit rolls to 0 and carries to the next digit.
  - Saturates at 16'h9999.
  - A hit takes priority over a same-cycle score tick: the score is not incremented.
  - start_pulse is ignored in this state.
- Entry to ST_OVER (same edge as the transition):
  - If score_bcd > best_bcd (plain 16-bit unsigned compare, valid for BCD), then best_bcd <= score_bcd and new_record <= 1.
  - Equal scores do not set new_record.
  - Lockout counter cleared.
- ST_OVER:
  - Lockout counter counts up and saturates at LOCKOUT_CYCLES.
  - start_pulse while count < LOCKOUT_CYCLES is discarded.
  - start_pulse once count == LOCKOUT_CYCLES -> ST_PLAY, applying the same clears as the IDLE -> PLAY transition.
- Latency:
  - Key accepted to game_state change: 1 cycle after start_pulse.
  - ball_hit high to game_state = ST_OVER: 1 cycle.
- score_bcd holds its value in IDLE and OVER for display.

Decomposition:
- Shared package game_pkg holds:
  - the state code constants ST_PLAY/ST_IDLE/ST_OVER (used by ball and display modules)
  - the BCD_DIGITS = 4 constant
  - the 16'h9999 saturation value
- One sub-module, key_debounce, with:
  - inputs: CLOCK_50, reset, key_n
  - outputs: pressed_level, press_pulse
  - parameter DEBOUNCE_CYCLES
- BCD increment is a function inside game_fsm, not a separate module.

Test Plan (DEBOUNCE_CYCLES=4, TICKS_PER_SEC=10, LOCKOUT_CYCLES=20):
1. Reset released; start_key_n held low 8 cycles -> one start_pulse ~6 cycles after the press (2 sync + 4 stable); game_state 1->0 one cycle later; score_bcd = 0.
2. start_key_n toggles every 2 cycles for 30 cycles -> no pulse; game_state stays 1.
3. In PLAY for 125 cycles -> score_bcd = 16'h0012; preload a run to 16'h0099 and advance 10 cycles -> 16'h0100; at 16'h9999 further ticks -> stays 16'h9999.
4. Score 16'h0007, ball_hit = 4'b0100 on the tick cycle -> game_state = 2 next cycle; score stays 16'h0007; best_bcd = 16'h0007; new_record = 1.
5. In OVER, start pulse at lockout count 10 -> stays 2; pulse at count ≥ 20 -> game_state = 0, score_bcd = 0, new_record = 0; ball_hit held high during the IDLE/OVER entry window -> ignored.
6. Next run ends at 16'h0005 -> best_bcd stays 16'h0007, new_record = 0; assert reset mid-PLAY -> game_state = 1 and best_bcd = 0 immediately, asynchronously without a clock edge.
